// File: rtl/sd_seq_gen.sv
// sd_seq_gen: bounded incrementing-sequence producer on a srdy/drdy interface.
// Latency: start at edge N -> busy after N, first offer after N+1 when srdy_pat[0]=1.
// Backpressure: a held offer (p_srdy & !p_drdy) freezes data, srdy and cadence position.
module sd_seq_gen #(
  parameter int width     = 8,
  parameter int pat_dep   = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [width-1:0]     init,
  input  logic [cnt_width-1:0] count,
  input  logic [pat_dep-1:0]   srdy_pat,
  output logic                 p_srdy,
  input  logic                 p_drdy,
  output logic [width-1:0]     p_data,
  output logic                 busy,
  output logic                 done,
  output logic [cnt_width-1:0] sent
);

  // Cadence pointer width; a one-slot pattern still gets a 1-bit pointer.
  localparam int DW = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   p_srdy_q;
  logic [width-1:0]       p_data_q;
  logic                   busy_q;
  logic                   done_q;
  logic [cnt_width-1:0]   sent_q;
  logic [cnt_width-1:0]   rem_q;
  logic [DW-1:0]          dpp_q;
  logic [pat_dep-1:0]     pat_q;

  logic                   xfer;
  logic                   hold;
  logic [cnt_width-1:0]   rem_d;
  logic [cnt_width-1:0]   sent_d;
  logic [DW-1:0]          dpp_d;
  logic [pat_dep-1:0]     pat_load;

  assign xfer = p_srdy_q & p_drdy;
  assign hold = p_srdy_q & ~p_drdy;

  // Next-value helpers shared by the RUN branch of the state machine.
  always_comb begin
    rem_d    = xfer ? (rem_q - cnt_width'(1)) : rem_q;
    sent_d   = (&sent_q) ? sent_q : (sent_q + cnt_width'(1));
    dpp_d    = (dpp_q == DW'(pat_dep - 1)) ? '0 : (dpp_q + DW'(1));
    // An empty cadence would stall forever, so treat it as "always offer".
    pat_load = (srdy_pat == '0) ? '1 : srdy_pat;
  end

  // Single-process FSM: IDLE/DONE wait for start, RUN walks the cadence and counts transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sent_q   <= '0;
      rem_q    <= '0;
      dpp_q    <= '0;
      pat_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            p_data_q <= init;
            rem_q    <= count;
            sent_q   <= '0;
            dpp_q    <= '0;
            pat_q    <= pat_load;
            p_srdy_q <= 1'b0;
            if (count != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // A held offer changes nothing; otherwise one cadence slot is consumed.
          if (!hold) begin
            if (xfer) begin
              p_data_q <= p_data_q + width'(1);
              sent_q   <= sent_d;
              rem_q    <= rem_d;
            end
            p_srdy_q <= pat_q[dpp_q] & (rem_d != '0);
            dpp_q    <= dpp_d;
            if (xfer && (rem_d == '0)) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              p_srdy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          p_srdy_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sent   = sent_q;

endmodule

// File: tb/tb_sd_seq_gen.sv
// Testbench for sd_seq_gen: cycle-by-cycle vector table plus a long randomised run
// against a strict +1 sequence checker with random consumer readiness.
module tb_sd_seq_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  init;
  logic [15:0] count;
  logic [7:0]  srdy_pat;
  logic        p_srdy;
  logic        p_drdy;
  logic [7:0]  p_data;
  logic        busy;
  logic        done;
  logic [15:0] sent;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sd_seq_gen #(.width(8), .pat_dep(8), .cnt_width(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .init     (init),
    .count    (count),
    .srdy_pat (srdy_pat),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_data   (p_data),
    .busy     (busy),
    .done     (done),
    .sent     (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [7:0]  in;
    logic [15:0] cnt;
    logic [7:0]  pat;
    logic        drdy;
    logic        e_srdy;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_sent;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic [7:0] in, input logic [15:0] c,
                     input logic [7:0] p, input logic d, input logic es, input logic [7:0] ed,
                     input logic eb, input logic edn, input logic [15:0] esn);
    vec_t v;
    v.rst = r; v.st = s; v.in = in; v.cnt = c; v.pat = p; v.drdy = d;
    v.e_srdy = es; v.e_data = ed; v.e_busy = eb; v.e_done = edn; v.e_sent = esn;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int          cycles;
    int          rx;
    int          seq_err;
    logic [7:0]  exp_d;
    logic        was_hold;
    logic [7:0]  held_d;
    logic [7:0]  rinit;

    reset = 1'b1; start = 1'b0; init = '0; count = '0; srdy_pat = '0; p_drdy = 1'b0;

    //   rst st  init   cnt  pat    drdy | srdy data  busy done sent
    add(1, 0, 8'h00, 0, 8'hFF, 1,   0, 8'h00, 0, 0, 0);   // reset state
    // basic burst
    add(0, 1, 8'h10, 5, 8'hFF, 1,   0, 8'h10, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h10, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h11, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h12, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h13, 1, 0, 3);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h14, 1, 0, 4);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h15, 0, 1, 5);
    // wrap-around, restarted on the first DONE cycle
    add(0, 1, 8'hFE, 4, 8'hFF, 1,   0, 8'hFE, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hFE, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'hFF, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h00, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h01, 1, 0, 3);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h02, 0, 1, 4);
    // back-pressure: 4 stalled cycles on the first offer
    add(0, 1, 8'h00, 3, 8'hFF, 1,   0, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h01, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h02, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h03, 0, 1, 3);
    // alternating cadence
    add(0, 1, 8'h20, 4, 8'h55, 1,   0, 8'h20, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h20, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h21, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h21, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h22, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h22, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h23, 1, 0, 3);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h23, 1, 0, 3);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h24, 0, 1, 4);
    // all-zero pattern behaves as all-ones
    add(0, 1, 8'h30, 2, 8'h00, 1,   0, 8'h30, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h30, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h31, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h32, 0, 1, 2);
    // count = 0, drdy high while srdy low
    add(0, 1, 8'h50, 0, 8'hFF, 1,   0, 8'h50, 0, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h50, 0, 1, 0);
    // start during RUN is ignored
    add(0, 1, 8'h60, 3, 8'hFF, 1,   0, 8'h60, 1, 0, 0);
    add(0, 1, 8'h99, 7, 8'h01, 1,   1, 8'h60, 1, 0, 0);
    add(0, 1, 8'h99, 7, 8'h01, 1,   1, 8'h61, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h62, 1, 0, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h63, 0, 1, 3);
    // reset after 2nd of 6 transfers, reset beats a simultaneous start
    add(0, 1, 8'h70, 6, 8'hFF, 1,   0, 8'h70, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h70, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h71, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h72, 1, 0, 2);
    add(1, 1, 8'h11, 3, 8'hFF, 1,   0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h40, 2, 8'hFF, 1,   0, 8'h40, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h40, 1, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h41, 1, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h42, 0, 1, 2);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; start = vq[i].st; init = vq[i].in;
      count = vq[i].cnt; srdy_pat = vq[i].pat; p_drdy = vq[i].drdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d {srdy,data,busy,done,sent}", i),
            64'({p_srdy, p_data, busy, done, sent}),
            64'({vq[i].e_srdy, vq[i].e_data, vq[i].e_busy, vq[i].e_done, vq[i].e_sent}));
    end

    // Long run: 1000 items, random cadence and random consumer readiness.
    rinit = 8'hC3;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; init = rinit; count = 16'd1000;
    srdy_pat = 8'($urandom) | 8'h01; p_drdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0; rx = 0; seq_err = 0; exp_d = rinit; was_hold = 1'b0; held_d = '0;
    while (rx < 1000 && cycles < 20000) begin
      @(negedge clk);
      p_drdy = 1'($urandom_range(0, 1));
      if (was_hold && (!p_srdy || p_data !== held_d)) seq_err++;
      if (p_srdy && p_drdy) begin
        if (p_data !== exp_d) seq_err++;
        exp_d = exp_d + 8'd1;
        rx++;
      end
      was_hold = p_srdy && !p_drdy;
      held_d   = p_data;
      @(posedge clk);
      cycles++;
    end
    #1;
    check("rand items received", 64'(rx), 64'd1000);
    check("rand sequence errors", 64'(seq_err), 64'd0);
    check("rand final {srdy,busy,done}", 64'({p_srdy, busy, done}), 64'(3'b001));
    check("rand final sent", 64'(sent), 64'd1000);
    check("rand final data", 64'(p_data), 64'(8'(rinit + 8'(1000))));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
